bcd_score_converter: RTL and testbench
======================================

Name: bcd_score_converter

Overview:
Sequential, parametrised binary-to-BCD converter for score and length display paths. It runs one shift-add-3 (double-dabble) iteration per clock, so a wide input needs no long combinational chain. It uses a valid/ready handshake on both sides. It detects values that do not fit in DIGITS decimal digits and saturates them. It sits between the game-state counters and the seven-segment/VGA score renderer.

Parameters:
BIN_WIDTH, 10, width of binary input (unsigned).
DIGITS, 3, number of BCD output digits; each digit is 4 bits, MS digit first in bcd_out.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  bin_in is valid.
in_ready  out  1  converter can accept a new value.
bin_in  in  BIN_WIDTH  unsigned binary value.
out_valid  out  1  bcd_out/overflow are valid.
out_ready  in  1  consumer accepts result.
bcd_out  out  4*DIGITS  BCD result; bits [3:0] = ones, [7:4] = tens, ...
overflow  out  1  value exceeded 10^DIGITS-1; qualified by out_valid.
busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, busy=0, bcd_out=0, overflow=0, internal shift/digit/counter registers cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: latch bin_in into shift register, clear digit registers and sticky overflow, load iteration counter = BIN_WIDTH, go to SHIFT.
- SHIFT: in_ready=0; on each edge, in order:
  - Every digit >= 5 gets +3.
  - The digit chain shifts left one bit, taking in the MSB of the shift register.
  - The shift register shifts left; the counter decrements.
  - Any 1 shifted out of the top digit's bit 3 sets the sticky overflow.
- Leaving SHIFT: the edge that performs iteration BIN_WIDTH also moves to DONE and sets out_valid=1. out_valid is therefore first high in the cycle after the BIN_WIDTH-th edge following the accept edge.
- DONE:
  - out_valid=1.
  - bcd_out and overflow are held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - No back-to-back accept in the same edge.
- Overflow: if the sticky flag is set, bcd_out presents all digits = 9 and overflow=1; otherwise overflow=0. The boundary value 10^DIGITS-1 produces no overflow; 10^DIGITS does.
- in_valid while in SHIFT or DONE is ignored (no latch, no error); bin_in changes during conversion have no effect.
- bcd_out outside DONE keeps its last presented value (0 after reset); consumers qualify with out_valid.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately to reset values; a pending result is discarded.
- Value 0 yields all-zero digits after the full BIN_WIDTH cycles; there is no early termination.
- Every digit in bcd_out is always a legal BCD code, 0-9, except the blank code 4'hF when the optional feature is enabled.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - In DONE, digits above the most significant nonzero digit are replaced with 4'hF, the renderer's blank code.
  - The ones digit is never blanked; value 0 shows as F..F0.
  - The saturated all-9s overflow result is never blanked.
- Undefined: leading zeros are output as 4'h0. No blanking logic is synthesised.

Test Plan:
- Defaults. Accept 10'd255 -> out_valid high exactly 10 edges after accept; bcd_out=12'h255, overflow=0.
- Accept 10'd0 -> bcd_out=12'h000 after 10 iterations; accept 10'd999 -> 12'h999, overflow=0.
- Accept 10'd1000 and 10'd1023 -> bcd_out=12'h999, overflow=1 for both.
- Accept 10'd42, hold out_ready=0 for 5 cycles while pulsing in_valid with bin_in=7:
  - bcd_out stays 12'h042 and out_valid stays 1; the 7 is ignored.
  - After out_ready=1, in_ready=1 the next cycle.
- Accept 10'd512, drop rst_n on cycle 4 of SHIFT -> outputs immediately at reset values. After release, accept 10'd17 -> 12'h017.
- LEADING_ZERO_BLANK_EN defined:
  - 10'd7 -> 12'hFF7.
  - 10'd40 -> 12'hF40.
  - 10'd0 -> 12'hFF0.
  - 10'd1000 -> 12'h999 with overflow=1.

Source files
------------

// File: rtl/bcd_score_converter.sv
// Sequential binary-to-BCD converter for score/length display paths.
// One shift-add-3 iteration per clock, valid/ready on both sides, saturates
// to all nines when the value does not fit in DIGITS decimal digits.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits with 4'hF.
module bcd_score_converter #(
  parameter int unsigned BIN_WIDTH = 10,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [BIN_WIDTH-1:0] r_shift,     w_shift_nxt;
  logic [BCD_W-1:0]     r_digits,    w_digits_nxt;
  logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
  logic                 r_ovf,       w_ovf_nxt;
  logic [BCD_W-1:0]     r_bcd,       w_bcd_nxt;
  logic                 r_ovf_out,   w_ovf_out_nxt;
  logic                 r_in_ready,  w_in_ready_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic                 r_busy,      w_busy_nxt;

  logic [BCD_W-1:0]     w_adj;
  logic [BCD_W-1:0]     w_digits_shl;
  logic                 w_ovf_iter;

  // Saturate on overflow, then optionally blank zeros above the top nonzero digit.
  function automatic logic [BCD_W-1:0] present(input logic [BCD_W-1:0] d,
                                               input logic             sat);
    logic [BCD_W-1:0] v;
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
`endif
    v = sat ? {DIGITS{4'h9}} : d;
`ifdef LEADING_ZERO_BLANK_EN
    lead = !sat;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) v[4*i +: 4] = 4'hF;
      else                               lead        = 1'b0;
    end
`endif
    return v;
  endfunction

  // Add-3 correction on every digit that is 5 or more.
  always_comb begin
    w_adj = r_digits;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_digits[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_digits[4*d +: 4] + 4'd3;
    end
  end

  assign w_digits_shl = {w_adj[BCD_W-2:0], r_shift[BIN_WIDTH-1]};
  assign w_ovf_iter   = r_ovf | w_adj[BCD_W-1];

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_digits_nxt    = r_digits;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_bcd_nxt       = r_bcd;
    w_ovf_out_nxt   = r_ovf_out;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state_nxt    = S_SHIFT;
          w_shift_nxt    = bin_in;
          w_digits_nxt   = '0;
          w_ovf_nxt      = 1'b0;
          w_cnt_nxt      = CNT_W'(BIN_WIDTH);
          w_in_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
        end
      end
      S_SHIFT: begin
        w_digits_nxt = w_digits_shl;
        w_shift_nxt  = r_shift << 1;
        w_cnt_nxt    = r_cnt - CNT_W'(1);
        w_ovf_nxt    = w_ovf_iter;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
          w_bcd_nxt       = present(w_digits_shl, w_ovf_iter);
          w_ovf_out_nxt   = w_ovf_iter;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_busy_nxt      = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_digits    <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_bcd       <= '0;
      r_ovf_out   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_digits    <= w_digits_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_bcd       <= w_bcd_nxt;
      r_ovf_out   <= w_ovf_out_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bcd_out   = r_bcd;
  assign overflow  = r_ovf_out;

endmodule

// File: tb/tb_bcd_score_converter.sv
// Scoreboard bench for bcd_score_converter: randomized and directed values,
// expected results derived from decimal arithmetic on the accepted value.
module tb_bcd_score_converter;

  localparam int unsigned BW    = 10;
  localparam int unsigned D     = 3;
  localparam int unsigned BCD_W = 4 * D;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [BW-1:0]    bin_in = '0;
  logic             in_ready;
  logic             out_valid;
  logic [BCD_W-1:0] bcd_out;
  logic             overflow;
  logic             busy;

  bcd_score_converter #(.BIN_WIDTH(BW), .DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             ovf;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  int               edge_cnt = 0;
  bit               hold = 1'b0;
  bit               in_flight = 1'b0;
  bit               was_flight;
  bit               exp_valid;
  int               acc_edge = 0;
  logic [BCD_W-1:0] last_bcd = '0;
  exp_t             e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, edge_cnt);
    end
  endtask

  // Decimal reference: digit i is (v / 10^i) % 10; saturate at 10^D.
  function automatic exp_t model(input int v);
    exp_t r;
    int   p;
    r.ovf = (v >= 10 ** D);
    p = 1;
    for (int i = 0; i < int'(D); i++) begin
      if (r.ovf) r.bcd[4*i +: 4] = 4'h9;
      else       r.bcd[4*i +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (!r.ovf && i > 0 && v < p) r.bcd[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Consumer: random back-pressure unless a hold is requested.
  always @(posedge clk) begin
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: tracks the handshake timeline and compares against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 1'b0;
      sb.delete();
      last_bcd = '0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bcd", 32'(bcd_out), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end else begin
      was_flight = in_flight;
      exp_valid  = in_flight && ((edge_cnt - acc_edge) >= int'(BW));
      chk("in_ready", 32'(in_ready), 32'(!was_flight));
      chk("busy", 32'(busy), 32'(was_flight));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb[0];
          chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
          chk("overflow", 32'(overflow), 32'(e.ovf));
          if (out_ready) begin
            last_bcd = e.bcd;
            void'(sb.pop_front());
            in_flight = 1'b0;
          end
        end
      end else if (!was_flight) begin
        chk("bcd_hold_idle", 32'(bcd_out), 32'(last_bcd));
      end
      if (!was_flight && in_valid) begin
        in_flight = 1'b1;
        acc_edge  = edge_cnt + 1;
        sb.push_back(model(int'(bin_in)));
      end
    end
  end

  task automatic send(input logic [BW-1:0] v);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    bin_in   = v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = BW'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [BW-1:0] dir [6];
    dir[0] = 10'd255; dir[1] = 10'd0;    dir[2] = 10'd999;
    dir[3] = 10'd1000; dir[4] = 10'd1023; dir[5] = 10'd7;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (dir[i]) send(dir[i]);
    send(10'd40);
    wait_drain();

    // Hold the result while pulsing in_valid with a value that must be ignored.
    hold = 1'b1;
    send(10'd42);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_timeout", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k % 2 == 0);
      bin_in   = 10'd7;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold     = 1'b0;
    wait_drain();

    // Abort a conversion with reset, then convert again.
    send(10'd512);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(10'd17);
    wait_drain();

    for (int k = 0; k < 40; k++) send(BW'($urandom_range(0, 1023)));
    send(10'd1000);
    send(10'd0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
